// File: rtl/sar_search_ctrl_pkg.sv
// Shared types for the successive-approximation search controller:
// state encoding, comparator flag bundle and the flag legality check.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DECIDE = 2'd2
  } sar_state_e;

  typedef struct packed {
    logic greater;
    logic lesser;
    logic equal;
  } cmp_flags_t;

  // A healthy comparator reports exactly one relation per trial.
  function automatic logic flags_legal(input cmp_flags_t f);
    return $onehot(f);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Controller <-> comparator/requester bundle; master = search controller side.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_greater;
  logic             cmp_lesser;
  logic             cmp_equal;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    input  start, cmp_greater, cmp_lesser, cmp_equal,
    output trial, busy, done, result, err
  );

  modport slave (
    output start, cmp_greater, cmp_lesser, cmp_equal,
    input  trial, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: resolves one bit per DECIDE, MSB first; optional SAR_EARLY_EXIT_EN stops on equal.
// Latency: done WIDTH*(SETTLE+1) cycles after start is sampled (fewer with early exit on a hit).
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic               clk,
  input  logic               rst,
  sar_search_ctrl_if.master  bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [BW-1:0]    BIT_MSB   = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam sar_state_e       STEP_STATE = (SETTLE == 0) ? S_DECIDE : S_SETTLE;

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  cmp_flags_t       flags;

  assign flags = '{greater: bus.cmp_greater, lesser: bus.cmp_lesser, equal: bus.cmp_equal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      trial_q   <= '0;
      result_q  <= '0;
      bit_idx_q <= BIT_MSB;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      trial_q   <= trial_d;
      result_q  <= result_d;
      bit_idx_q <= bit_idx_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    result_d  = result_q;
    bit_idx_d = bit_idx_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          trial_d   = TRIAL_MSB;
          bit_idx_d = BIT_MSB;
          settle_d  = '0;
          busy_d    = 1'b1;
          state_d   = STEP_STATE;
        end
      end

      S_SETTLE: begin
        if (int'(settle_q) == SETTLE - 1) begin
          settle_d = '0;
          state_d  = S_DECIDE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_DECIDE: begin
        if (!flags_legal(flags)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          trial_d = '0;
          state_d = S_IDLE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (flags.equal) begin
          result_d = trial_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
`endif
        else begin
          // Target below the trial means this bit overshoots and must be dropped.
          if (flags.lesser) trial_d[bit_idx_q] = 1'b0;
          if (bit_idx_q != '0) begin
            trial_d[bit_idx_q - 1'b1] = 1'b1;
            bit_idx_d = bit_idx_q - 1'b1;
            settle_d  = '0;
            state_d   = STEP_STATE;
          end else begin
            result_d = trial_d;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule
